// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling and framing-error detection.
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   rx         in   serial line, idle high, asynchronous to clk
//   data       out  last good received byte (LSB first on the line)
//   rx_done    out  one-cycle strobe: data valid, frame good
//   frame_err  out  one-cycle strobe: stop bit sampled low
//   busy       out  high whenever the receiver is not idle
module uart_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       rx_done,
   output logic       frame_err,
   output logic       busy
);
   localparam int CW = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt_q;
   logic [2:0]             idx_q;
   logic [7:0]             shreg_q;
   logic                   rxs;

   // Synchronizer resets to the idle level so reset never looks like a start bit.
   always_ff @(posedge clk)
      if (rst) sync_q <= '1;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx};

   assign rxs  = sync_q[SYNC_STAGES-1];
   assign busy = state_q != IDLE;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shreg_q   <= '0;
         data      <= '0;
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (!rxs) state_q <= START;
            end
            // Re-check the line at mid start bit so short glitches are rejected.
            START: if (cnt_q == HALF) begin
               cnt_q   <= '0;
               idx_q   <= '0;
               state_q <= rxs ? IDLE : DATA;
            end else cnt_q <= cnt_q + 1'b1;
            DATA: if (cnt_q == FULL) begin
               cnt_q          <= '0;
               shreg_q[idx_q] <= rxs;
               if (idx_q == 3'd7) state_q <= STOP;
               else               idx_q   <= idx_q + 1'b1;
            end else cnt_q <= cnt_q + 1'b1;
            // Sampling at mid stop bit leaves half a bit to get back to IDLE
            // before a back-to-back start edge arrives.
            STOP: if (cnt_q == FULL) begin
               cnt_q   <= '0;
               state_q <= DONE;
               if (rxs) begin
                  data    <= shreg_q;
                  rx_done <= 1'b1;
               end else frame_err <= 1'b1;
            end else cnt_q <= cnt_q + 1'b1;
            DONE: begin
               cnt_q   <= '0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a frame-level scoreboard.
module tb_uart_rx;
   localparam int CPB  = 16;
   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] data;
   logic       rx_done, frame_err, busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cyc = 0;
   int fall_cyc = 0;
   int start_cyc = 0;
   bit busy_prev = 1'b0;
   bit busy_seen = 1'b0;
   logic [7:0] last_good = 8'h00;
   logic [8:0] got_q[$];
   logic [8:0] exp_q[$];

   uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst(rst), .rx(rx), .data(data),
      .rx_done(rx_done), .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Monitor: every strobe becomes an event {is_err, data}.
   always @(negedge clk) begin
      cyc++;
      if (rx_done || frame_err) begin
         chk("strobe_excl", 32'(rx_done & frame_err), 32'd0);
         got_q.push_back({frame_err, data});
      end
      if (rx_done) done_cyc = cyc;
      if (busy_prev && !busy) fall_cyc = cyc;
      if (busy === 1'b1) busy_seen = 1'b1;
      busy_prev = (busy === 1'b1);
   end

   task automatic send_bit(input logic v);
      rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic idle_bits(input int n);
      rx = 1'b1;
      repeat (n * CPB) @(negedge clk);
   endtask

   // Serializer and scoreboard: a good frame yields its byte, a bad stop
   // yields a frame error with data still holding the last good byte.
   task automatic tx_frame(input logic [7:0] b, input bit stop_ok);
      if (stop_ok) begin
         exp_q.push_back({1'b0, b});
         last_good = b;
      end else exp_q.push_back({1'b1, last_good});
      start_cyc = cyc;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop_ok);
   endtask

   task automatic check_events(input string tag);
      logic [8:0] g, e;
      chk({tag, "_count"}, got_q.size(), exp_q.size());
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         chk(tag, {23'd0, g}, {23'd0, e});
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [7:0] b;
      bit ok;
      repeat (3) begin
         @(negedge clk);
         chk("rst_data", {24'd0, data}, 32'h00);
         chk("rst_done", {31'd0, rx_done}, 32'd0);
         chk("rst_ferr", {31'd0, frame_err}, 32'd0);
         chk("rst_busy", {31'd0, busy}, 32'd0);
      end
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check_events("rst_noev");

      tx_frame(8'hA5, 1'b1);
      idle_bits(1);
      chk("a5_latency", 32'((done_cyc - start_cyc >= 153) && (done_cyc - start_cyc <= 157)), 32'd1);
      chk("a5_busy_fall", 32'((fall_cyc > done_cyc) && (fall_cyc - done_cyc <= 2)), 32'd1);
      check_events("a5");

      tx_frame(8'h00, 1'b1);
      tx_frame(8'hFF, 1'b1);
      tx_frame(8'h3C, 1'b1);
      idle_bits(1);
      check_events("b2b");

      tx_frame(8'h5A, 1'b0);
      idle_bits(2);
      tx_frame(8'h81, 1'b1);
      idle_bits(1);
      check_events("ferr");

      busy_seen = 1'b0;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      idle_bits(2);
      chk("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
      chk("glitch_idle", {31'd0, busy}, 32'd0);
      check_events("glitch");

      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      rx = 1'b0;
      repeat (CPB / 2) @(negedge clk);
      rst = 1'b1;
      rx  = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_busy", {31'd0, busy}, 32'd0);
      idle_bits(2);
      check_events("mrst_abort");
      tx_frame(8'h12, 1'b1);
      idle_bits(1);
      check_events("mrst_12");

      for (int n = 0; n < 256; n++) begin
         b  = 8'($urandom);
         ok = ($urandom_range(0, 7) != 0);
         tx_frame(b, ok);
         idle_bits($urandom_range(0, 2) + (ok ? 0 : 1));
      end
      idle_bits(1);
      check_events("loop");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
